value_predict_table: RTL

//  Last-value prediction table feeding the load value-prediction stage. Indexed by load PC;

---
 rtl/value_predict_table.sv | 121 ++++++++++++
 1 files changed

// File: rtl/value_predict_table.sv
// Last-value prediction table: PC-indexed entries of tag, last committed value and
// saturating confidence; one-cycle lookup plus training from resolved loads.
module value_predict_table #(
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned TAG_WIDTH   = 8,
  parameter int unsigned CONF_BITS   = 2,
  parameter int unsigned CONF_THRESH = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  pred_valid,
  output logic                  pred_hit,
  output logic                  pred_confident,
  output logic [DATA_WIDTH-1:0] pred_value,
  input  logic                  update_valid,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic [DATA_WIDTH-1:0] update_value,
  input  logic                  update_was_conf,
  output logic [15:0]           stat_correct,
  output logic [15:0]           stat_mispredict
);

  localparam int unsigned ENTRIES    = 1 << INDEX_WIDTH;
  localparam int unsigned STAT_WIDTH = 16;
  localparam int unsigned IDX_LO     = 2;
  localparam int unsigned TAG_LO     = INDEX_WIDTH + 2;
  localparam int unsigned TAG_HI     = INDEX_WIDTH + TAG_WIDTH + 1;

  localparam logic [CONF_BITS-1:0]  CONF_MAX   = {CONF_BITS{1'b1}};
  localparam logic [CONF_BITS-1:0]  CONF_LIMIT = CONF_BITS'(CONF_THRESH);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX   = {STAT_WIDTH{1'b1}};

  logic [ENTRIES-1:0]                valid_q;
  logic [ENTRIES-1:0][CONF_BITS-1:0] conf_q;
  logic [TAG_WIDTH-1:0]              tag_q   [ENTRIES];
  logic [DATA_WIDTH-1:0]             value_q [ENTRIES];

  logic [INDEX_WIDTH-1:0] lk_idx;
  logic [TAG_WIDTH-1:0]   lk_tag;
  logic                   lk_hit;
  logic                   lk_conf;
  logic [INDEX_WIDTH-1:0] up_idx;
  logic [TAG_WIDTH-1:0]   up_tag;
  logic                   up_hit;
  logic                   up_match;
  logic                   unused_pc_bits;

  // PC decode and table read; both ports see the contents from before this cycle's update
  always_comb begin
    lk_idx   = lookup_pc[INDEX_WIDTH+1:IDX_LO];
    lk_tag   = lookup_pc[TAG_HI:TAG_LO];
    lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_conf  = conf_q[lk_idx] >= CONF_LIMIT;
    up_idx   = update_pc[INDEX_WIDTH+1:IDX_LO];
    up_tag   = update_pc[TAG_HI:TAG_LO];
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_match = up_hit && (value_q[up_idx] == update_value);
  end

  assign unused_pc_bits = ^{lookup_pc[ADDR_WIDTH-1:TAG_HI+1], lookup_pc[IDX_LO-1:0],
                            update_pc[ADDR_WIDTH-1:TAG_HI+1], update_pc[IDX_LO-1:0]};

  // Prediction result register; outputs other than pred_valid hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid     <= 1'b0;
      pred_hit       <= 1'b0;
      pred_confident <= 1'b0;
      pred_value     <= '0;
    end else begin
      pred_valid <= lookup_valid;
      if (lookup_valid) begin
        pred_hit       <= lk_hit;
        pred_confident <= lk_hit && lk_conf;
        pred_value     <= lk_hit ? value_q[lk_idx] : '0;
      end
    end
  end

  // Valid bits and confidence counters
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      conf_q  <= '0;
    end else if (update_valid) begin
      if (up_match) begin
        if (conf_q[up_idx] != CONF_MAX) conf_q[up_idx] <= conf_q[up_idx] + CONF_BITS'(1);
      end else begin
        valid_q[up_idx] <= 1'b1;
        conf_q[up_idx]  <= '0;
      end
    end
  end

  // Tag/value storage; a mismatch or miss (re)writes the entry, no reset needed
  always_ff @(posedge clk) begin
    if (!rst && update_valid && !up_match) begin
      tag_q[up_idx]   <= up_tag;
      value_q[up_idx] <= update_value;
    end
  end

  // Outcome statistics for loads that had been predicted confidently
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_correct    <= '0;
      stat_mispredict <= '0;
    end else if (update_valid && update_was_conf) begin
      if (up_match) begin
        if (stat_correct != STAT_MAX) stat_correct <= stat_correct + STAT_WIDTH'(1);
      end else begin
        if (stat_mispredict != STAT_MAX) stat_mispredict <= stat_mispredict + STAT_WIDTH'(1);
      end
    end
  end

endmodule
